pmp_check_seq: RTL
==================

PMP_CHECK_SEQ -- requirements
Module: pmp_check_seq

Interface
REQ-001 SHALL have parameter PLEN, default 56, physical address width.
REQ-002 SHALL have parameter PMP_LEN, default 54, pmpaddr width (PLEN-2).
REQ-003 SHALL have parameter NR_ENTRIES, default 16, number of PMP entries (1..64).
REQ-004 SHALL have parameter LANES, default 4, entries evaluated per cycle; must divide NR_ENTRIES.
REQ-005 SHALL have ports:
 clk_i  in  1  clock.
 rst_i  in  1  synchronous, active-high reset.
 flush_i  in  1  abort the in-flight check.
 req_valid_i  in  1  request valid.
 req_ready_o  out  1  request accepted when valid&ready.
 req_addr_i  in  PLEN  byte address to check.
 req_type_i  in  2  00=R, 01=W, 10=X; 11 is illegal and always denied.
 req_priv_i  in  2  00=U, 01=S, 11=M.
 conf_addr_i  in  NR_ENTRIES*PMP_LEN  pmpaddr per entry; entry i at [i*PMP_LEN +: PMP_LEN].
 conf_mode_i  in  NR_ENTRIES*2  00=OFF, 01=TOR, 10=NA4, 11=NAPOT.
 conf_perm_i  in  NR_ENTRIES*3  {X,W,R} per entry.
 conf_lock_i  in  NR_ENTRIES  L bit per entry.
 resp_valid_o  out  1  result valid.
 resp_ready_i  in  1  result consumed when valid&ready.
 resp_allow_o  out  1  access permitted.
 resp_hit_o  out  1  an entry matched.
 resp_idx_o  out  $clog2(NR_ENTRIES), minimum 1  index of the matching entry.

Function
REQ-006 SHALL be a three-state FSM: IDLE, SCAN, RESP.
REQ-007 IDLE: req_ready_o=1; on accept, SHALL register addr, type and priv, set group counter g=0, and go to SCAN.
REQ-008 SCAN: in group g, SHALL evaluate entries g*LANES .. g*LANES+LANES-1 in one cycle; req_ready_o=0.
REQ-009 Entry matching SHALL use these rules:
 - OFF: never matches.
 - TOR: matches when (prev<<2) <= addr < (conf_addr<<2); prev is conf_addr of entry i-1, and 0 for entry 0, regardless of entry i-1's mode.
 - NA4: matches when addr[PLEN-1:2] == conf_addr.
 - NAPOT: t = count of trailing ones in conf_addr; size = t+3; matches when addr and (conf_addr<<2) are equal with the low size bits masked. An all-ones conf_addr matches every address.
REQ-010 All comparisons SHALL be unsigned at PLEN bits; the TOR top bound SHALL be zero-extended before the shift, with no wrap.
REQ-011 Priority SHALL go to the lowest-indexed matching entry, both within a group and across groups.
REQ-012 On the first group containing a match, SHALL latch hit=1 and the index, then go to RESP on the next edge; later groups are not scanned (early exit).
REQ-013 If the last group (g = NR_ENTRIES/LANES-1) has no match, SHALL go to RESP with hit=0 and idx=0.
REQ-014 Allow on hit: if priv=M and L=0, allow=1; otherwise allow = perm bit selected by type (R, W or X).
REQ-015 Allow on miss: allow=1 if priv=M, else allow=0.
REQ-016 req_type 11 SHALL give allow=0 in all cases.
REQ-017 RESP: resp_valid_o=1; allow, hit and idx held stable; on resp_ready_i go to IDLE. req_ready_o=0 in RESP (no overlap).
REQ-018 Latency from accept to resp_valid_o SHALL be k+1 cycles, where k = index of the matching group + 1 on a hit, or NR_ENTRIES/LANES on a miss.
REQ-019 conf_* inputs SHALL be sampled combinationally during SCAN; changing them mid-scan is a caller error with undefined result. No assertion is required.
REQ-020 flush_i in SCAN or RESP SHALL go to IDLE on the next edge, with no response and resp_valid_o dropping that edge.
REQ-021 flush_i in IDLE SHALL block acceptance that cycle: req_ready_o=0.

Reset
REQ-022 rst_i SHALL take priority over flush_i and all handshakes.
REQ-023 On reset, SHALL force state=IDLE, g=0, resp_valid_o=0, resp_allow_o=0, resp_hit_o=0, resp_idx_o=0.
REQ-024 Reset mid-SCAN or mid-RESP SHALL discard the transaction; req_ready_o=1 on the first cycle after reset deasserts.

Verification
REQ-025 NAPOT, NR_ENTRIES=16, LANES=4: entry 5 NAPOT, conf_addr=0x2000_03FF (t=10, 8 KiB at 0x8000_0000), perm R only; U read of 0x8000_1FFC -> hit=1, idx=5, allow=1, resp_valid_o 3 cycles after accept. A U write of the same address -> allow=0.
REQ-026 TOR: entry 0 TOR, conf_addr=0x400 (range [0, 0x1000)), perm RWX. Address 0xFFF -> hit=1, idx=0, allow=1, latency 2. Address 0x1000 with all other entries OFF -> hit=0, S-mode allow=0, M-mode allow=1, latency 5.
REQ-027 Priority/lock: entries 2 and 9 both match 0x100; entry 2 has L=1, perm=000. M-mode read -> idx=2, allow=0.
REQ-028 Backpressure: resp_ready_i held 0 for 10 cycles -> resp_valid_o and the outputs stay stable and req_ready_o=0 throughout; IDLE on the cycle after ready rises.
REQ-029 flush_i asserted in the second SCAN cycle -> no resp_valid_o pulse; the next request is accepted and answered correctly.
REQ-030 rst_i asserted during RESP -> resp_valid_o=0 on the next edge and all outputs zero.

Source files
------------

// File: rtl/pmp_check_if.sv
// Request/response handshake bundle for the sequential PMP checker.
// The requester drives the master side, the checker sits on the slave side.
interface pmp_check_if #(
    parameter int PLEN       = 56,
    parameter int NR_ENTRIES = 16
);
    localparam int IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    logic             req_valid_i;
    logic             req_ready_o;
    logic [PLEN-1:0]  req_addr_i;
    logic [1:0]       req_type_i;
    logic [1:0]       req_priv_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic             resp_allow_o;
    logic             resp_hit_o;
    logic [IDX_W-1:0] resp_idx_o;

    modport master (
        output req_valid_i, req_addr_i, req_type_i, req_priv_i,
        output resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_allow_o,
        input  resp_hit_o, resp_idx_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_type_i, req_priv_i,
        input  resp_ready_i,
        output req_ready_o, resp_valid_o, resp_allow_o,
        output resp_hit_o, resp_idx_o
    );
endinterface

// File: rtl/pmp_check_seq.sv
// Sequential PMP checker: scans LANES entries per cycle, lowest index wins,
// stops at the first matching group and holds the verdict until consumed.
module pmp_check_seq #(
    parameter int PLEN       = 56,
    parameter int PMP_LEN    = 54,
    parameter int NR_ENTRIES = 16,
    parameter int LANES      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    pmp_check_if.slave                    bus,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
    input  logic [NR_ENTRIES*2-1:0]       conf_mode_i,
    input  logic [NR_ENTRIES*3-1:0]       conf_perm_i,
    input  logic [NR_ENTRIES-1:0]         conf_lock_i
);
    localparam int IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int NGRP  = NR_ENTRIES / LANES;
    localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int CW    = (PMP_LEN + 2 > PLEN) ? PMP_LEN + 2 : PLEN;
    localparam logic [GW-1:0] LAST_G = GW'(NGRP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PLEN-1:0]  addr_q;
    logic [1:0]       type_q;
    logic [1:0]       priv_q;
    logic [GW-1:0]    g_q;
    logic             allow_q;
    logic             hit_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept;
    logic             is_m;
    logic             type_ok;
    logic             miss_allow;
    logic             grp_hit;
    logic             grp_allow;
    logic [IDX_W-1:0] grp_idx;
    logic [CW-1:0]    addr_ext;

    assign accept     = (state_q == IDLE) && !flush_i && bus.req_valid_i;
    assign is_m       = (priv_q == 2'b11);
    assign type_ok    = (type_q != 2'b11);
    assign miss_allow = is_m && type_ok;
    assign addr_ext   = CW'(addr_q);

    // Match the current group; the first matching lane carries the verdict.
    always_comb begin : grp_eval
        int               e;
        int               pe;
        logic [PMP_LEN-1:0] pa;
        logic [PMP_LEN-1:0] pp;
        logic [PMP_LEN-1:0] nm;
        logic [CW-1:0]    top;
        logic [CW-1:0]    bot;
        logic [CW-1:0]    lowm;
        logic [2:0]       perm;
        logic             sel;
        logic             m;
        grp_hit   = 1'b0;
        grp_allow = 1'b0;
        grp_idx   = '0;
        e    = 0;
        pe   = 0;
        pa   = '0;
        pp   = '0;
        nm   = '0;
        top  = '0;
        bot  = '0;
        lowm = '0;
        perm = '0;
        sel  = 1'b0;
        m    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            e    = int'(g_q) * LANES + l;
            pe   = (e > 0) ? e - 1 : 0;
            pa   = conf_addr_i[e*PMP_LEN +: PMP_LEN];
            pp   = (e > 0) ? conf_addr_i[pe*PMP_LEN +: PMP_LEN] : '0;
            top  = CW'(pa) << 2;
            bot  = CW'(pp) << 2;
            // Trailing ones of pmpaddr plus the next bit give the NAPOT span.
            nm   = pa ^ (pa + PMP_LEN'(1));
            lowm = (CW'(nm) << 2) | CW'(2'b11);
            unique case (conf_mode_i[e*2 +: 2])
                2'b01:   m = (addr_ext >= bot) && (addr_ext < top);
                2'b10:   m = (addr_ext >> 2) == CW'(pa);
                2'b11:   m = ((addr_ext ^ top) & ~lowm) == '0;
                default: m = 1'b0;
            endcase
            perm = conf_perm_i[e*3 +: 3];
            unique case (type_q)
                2'b00:   sel = perm[0];
                2'b01:   sel = perm[1];
                2'b10:   sel = perm[2];
                default: sel = 1'b0;
            endcase
            if (m && !grp_hit) begin
                grp_hit   = 1'b1;
                grp_idx   = IDX_W'(e);
                grp_allow = type_ok && ((is_m && !conf_lock_i[e]) || sel);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: begin
                if (flush_i)
                    state_d = IDLE;
                else if (grp_hit || g_q == LAST_G)
                    state_d = RESP;
            end
            RESP: if (flush_i || bus.resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            addr_q  <= '0;
            type_q  <= '0;
            priv_q  <= '0;
            allow_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= bus.req_addr_i;
                type_q <= bus.req_type_i;
                priv_q <= bus.req_priv_i;
                g_q    <= '0;
            end
            if (state_q == SCAN && !flush_i) begin
                if (grp_hit) begin
                    hit_q   <= 1'b1;
                    idx_q   <= grp_idx;
                    allow_q <= grp_allow;
                end else if (g_q == LAST_G) begin
                    hit_q   <= 1'b0;
                    idx_q   <= '0;
                    allow_q <= miss_allow;
                end else begin
                    g_q <= g_q + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE) && !flush_i;
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_allow_o = allow_q;
    assign bus.resp_hit_o   = hit_q;
    assign bus.resp_idx_o   = idx_q;
endmodule
